// File: rtl/psdsqrt_pkg.sv
// Shared types and sizing helper for the psd_sqrt sequential square-root block.
package psdsqrt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } psdsqrt_state_t;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] f;
    } psdsqrt_dims_t;

    // Iteration count and fractional root bits for a given operand width and extension.
    function automatic psdsqrt_dims_t psdsqrt_dims(input int nbitsin, input int kbits);
        psdsqrt_dims_t d;
        d.n = 32'((nbitsin + kbits) / 2);
        d.f = 32'(kbits / 2);
        return d;
    endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One restoring square-root digit step: folds two operand bits into the remainder
// and decides the next root bit.
module psdsqrt_step #(
    parameter int N = 20
) (
    input  logic [N+1:0] rem,
    input  logic [N-1:0] root,
    input  logic [1:0]   bits,
    output logic [N+1:0] rem_nxt,
    output logic [N-1:0] root_nxt
);

    logic [N+1:0] trial_s;
    logic [N+1:0] test_s;
    // The remainder never exceeds 2*root, so its two top bits are zero before the shift.
    logic         unused_s;

    assign unused_s = &{1'b0, rem[N+1:N]};

    // Trial subtraction of (root<<2)|1 from the shifted-in remainder.
    always_comb begin
        trial_s  = {rem[N-1:0], bits};
        test_s   = {root, 2'b01};
        rem_nxt  = trial_s;
        root_nxt = {root[N-2:0], 1'b0};
        if (trial_s >= test_s) begin
            rem_nxt  = trial_s - test_s;
            root_nxt = {root[N-2:0], 1'b1};
        end else begin
            rem_nxt  = trial_s;
            root_nxt = {root[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/psd_sqrt.sv
// Sequential rounded integer square root, one root bit per clock.
// Define PSDSQRT_ROUND_EN for round-half-up with saturation; otherwise the result truncates.
module psd_sqrt
    import psdsqrt_pkg::*;
#(
    parameter int NBITSIN = 32,
    parameter int k       = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NBITSIN-1:0]   xin,
    output logic [NBITSIN/2-1:0] sqrt
);

    localparam psdsqrt_dims_t DIMS = psdsqrt_dims(NBITSIN, k);
    localparam int N  = int'(DIMS.n);
    localparam int F  = int'(DIMS.f);
    localparam int W  = NBITSIN + k;
    localparam int CW = $clog2(N + 1);
    localparam int RW = N - F;

    psdsqrt_state_t state_r, state_nxt_s;
    logic [W-1:0]   x_r,    x_nxt_s;
    logic [N+1:0]   rem_r,  rem_nxt_s,  rem_step_s;
    logic [N-1:0]   root_r, root_nxt_s, root_step_s;
    logic [CW-1:0]  cnt_r,  cnt_nxt_s;
    logic [RW-1:0]  sqrt_r, sqrt_nxt_s, res_s;

    psdsqrt_step #(.N(N)) u_step (
        .rem      (rem_r),
        .root     (root_r),
        .bits     (x_r[W-1:W-2]),
        .rem_nxt  (rem_step_s),
        .root_nxt (root_step_s)
    );

`ifdef PSDSQRT_ROUND_EN
    logic [RW:0] rnd_s;

    // Round half up on the first fractional bit; a carry out saturates to all ones.
    always_comb begin
        rnd_s = {1'b0, root_r[N-1:F]} + {{RW{1'b0}}, root_r[F-1]};
        if (rnd_s[RW]) begin
            res_s = {RW{1'b1}};
        end else begin
            res_s = rnd_s[RW-1:0];
        end
    end
`else
    // Truncation keeps only the integer part of the root.
    always_comb begin
        res_s = root_r[N-1:F];
    end
`endif

    // Next-state and datapath update; start restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        rem_nxt_s   = rem_r;
        root_nxt_s  = root_r;
        cnt_nxt_s   = cnt_r;
        if (start) begin
            state_nxt_s = RUN;
            x_nxt_s     = {xin, {k{1'b0}}};
            rem_nxt_s   = {(N+2){1'b0}};
            root_nxt_s  = {N{1'b0}};
            cnt_nxt_s   = CW'(N);
        end else begin
            case (state_r)
                RUN: begin
                    x_nxt_s     = {x_r[W-3:0], 2'b00};
                    rem_nxt_s   = rem_step_s;
                    root_nxt_s  = root_step_s;
                    cnt_nxt_s   = cnt_r - CW'(1);
                    state_nxt_s = (cnt_r == CW'(1)) ? IDLE : RUN;
                end
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Result register follows the pre-update root whenever stop is sampled.
    always_comb begin
        if (stop) begin
            sqrt_nxt_s = res_s;
        end else begin
            sqrt_nxt_s = sqrt_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            x_r     <= {W{1'b0}};
            rem_r   <= {(N+2){1'b0}};
            root_r  <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            sqrt_r  <= {RW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            x_r     <= x_nxt_s;
            rem_r   <= rem_nxt_s;
            root_r  <= root_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sqrt_r  <= sqrt_nxt_s;
        end
    end

    assign sqrt = sqrt_r;

endmodule

// File: tb/tb_psd_sqrt.sv
// Directed bench for psd_sqrt with hand-computed roots for both rounding builds.
module tb_psd_sqrt;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] xin;
    logic [15:0] sqrt;

    int total;
    int bad;

    psd_sqrt #(.NBITSIN(32), .k(8)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .xin   (xin),
        .sqrt  (sqrt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] val);
        @(negedge clock);
        start = 1'b1;
        xin   = val;
        @(negedge clock);
        start = 1'b0;
        xin   = 32'hDEAD_BEEF;
    endtask

    // Called right after pulse_start returns: stop lands on edge 21 after start.
    task automatic stop_after_run();
        repeat (20) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] val, input logic [31:0] exp);
        pulse_start(val);
        stop_after_run();
        check_eq(tag, {16'h0000, sqrt}, exp);
    endtask

    logic [31:0] vin  [10];
    logic [31:0] vexp [10];

    initial begin
        total = 0;
        bad   = 0;
        start = 1'b0;
        stop  = 1'b0;
        xin   = 32'h0000_0000;
        reset = 1'b0;

        vin[0] = 32'd123456;     vexp[0] = 32'd351;
        vin[1] = 32'd109876;     vexp[1] = 32'd331;
        vin[2] = 32'd543210;     vexp[2] = 32'd737;
        vin[3] = 32'd12;         vexp[3] = 32'd3;
        vin[4] = 32'd0;          vexp[4] = 32'd0;
        vin[5] = 32'hFFFF_FFFF;  vexp[5] = 32'h0000_FFFF;
`ifdef PSDSQRT_ROUND_EN
        vin[6] = 32'd13;         vexp[6] = 32'd4;
        vin[7] = 32'd1057;       vexp[7] = 32'd33;
        vin[8] = 32'd4291;       vexp[8] = 32'd66;
        vin[9] = 32'd65535;      vexp[9] = 32'd256;
`else
        vin[6] = 32'd13;         vexp[6] = 32'd3;
        vin[7] = 32'd1057;       vexp[7] = 32'd32;
        vin[8] = 32'd4291;       vexp[8] = 32'd65;
        vin[9] = 32'd65535;      vexp[9] = 32'd255;
`endif

        #12;
        check_eq("reset_state", {16'h0000, sqrt}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d_%0d", i, vin[i]), vin[i], vexp[i]);
        end

        // Restart five cycles into a run; only the second operand matters.
        pulse_start(32'd123456);
        repeat (3) @(negedge clock);
        pulse_start(32'd13);
        stop_after_run();
        check_eq("restart", {16'h0000, sqrt}, vexp[6]);

        // Two stops after one run give the same value, and sqrt holds in between.
        pulse_start(32'd543210);
        stop_after_run();
        check_eq("stop_first", {16'h0000, sqrt}, 32'd737);
        repeat (7) @(negedge clock);
        check_eq("hold_between", {16'h0000, sqrt}, 32'd737);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_eq("stop_second", {16'h0000, sqrt}, 32'd737);

        // Start and stop together: result comes from the old root, new run proceeds.
        @(negedge clock);
        start = 1'b1;
        stop  = 1'b1;
        xin   = 32'd109876;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("start_stop_same", {16'h0000, sqrt}, 32'd737);
        stop_after_run();
        check_eq("after_same_cycle", {16'h0000, sqrt}, 32'd331);

        // Reset mid-run clears the result at once; a later bare stop yields zero.
        pulse_start(32'd123456);
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("async_reset", {16'h0000, sqrt}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);
        check_eq("post_reset_idle", {16'h0000, sqrt}, 32'd0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_eq("stop_no_start", {16'h0000, sqrt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
